// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: shares one 8-way resource among 8 requesters.
// One grant at a time, held until done or withdrawal, then one turnaround
// cycle before re-arbitration from the slot after the last owner.
// Optional build macro ARB_TIMEOUT_EN adds a MAX_HOLD-cycle forced release
// with a one-cycle timeout pulse; without it timeout is tied low.
module rr_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt_onehot,
  output logic       busy,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [7:0] gnt_onehot_q, gnt_onehot_d;
  logic       busy_q, busy_d;
  logic [2:0] sel_idx;
  logic       normal_rel;
  logic       expire;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Pick the first requester at or after ptr_q, wrapping modulo 8.
  always_comb begin
    sel_idx = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) begin
        sel_idx = ptr_q + 3'(i);
      end
    end
  end

  // Release conditions for the current owner; done and withdrawal merge into one release.
  always_comb begin
    normal_rel = done || !req[gnt_idx_q];
`ifdef ARB_TIMEOUT_EN
    expire     = (hold_cnt_q == 8'(MAX_HOLD - 1)) && !normal_rel;
`else
    expire     = 1'b0;
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d   = StGrant;
          gnt_idx_d = sel_idx;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end
      StGrant: begin
        if (normal_rel || expire) begin
          state_d = StRelease;
          ptr_d   = gnt_idx_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
          timeout_d = expire;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    gnt_valid_d  = (state_d == StGrant);
    gnt_onehot_d = gnt_valid_d ? (8'd1 << gnt_idx_d) : 8'd0;
    busy_d       = (state_d != StIdle);
  end

  // All state and outputs; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= 3'd0;
      gnt_idx_q    <= 3'd0;
      gnt_valid_q  <= 1'b0;
      gnt_onehot_q <= 8'd0;
      busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q   <= 8'd0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_onehot_q <= gnt_onehot_d;
      busy_q       <= busy_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q   <= hold_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign busy       = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against an owner/cooldown reference model.
module tb_rr_grant_ctrl;

  localparam int unsigned MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       busy;
  logic       timeout;

  rr_grant_ctrl #(.MAX_HOLD(MaxHold)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_onehot(gnt_onehot),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: who owns the resource, whether a turnaround is pending.
  int m_owner;
  int m_last;
  int m_ptr;
  int m_hold;
  bit m_cool;
  bit m_to;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       b;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [13:0] dut_vec();
    return {gnt_valid, gnt_idx, gnt_onehot, busy, timeout};
  endfunction

  function automatic logic [13:0] model_vec();
    logic       v;
    logic [7:0] oh;
    v  = (m_owner >= 0);
    oh = v ? 8'(1 << m_last) : 8'h00;
    return {v, 3'(m_last), oh, v || m_cool, m_to};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_cool  = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    m_to = 1'b0;
    if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_owner >= 0) begin
      bit ended;
      bit expire;
      m_hold++;
      ended  = d || !r[m_owner];
      expire = 1'b0;
`ifdef ARB_TIMEOUT_EN
      expire = !ended && (m_hold == MaxHold);
`endif
      if (ended || expire) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = 1'b1;
        m_to    = expire;
      end
    end else if (r != 8'h00) begin
      int best;
      int bd;
      best = -1;
      bd   = 9;
      for (int i = 0; i < 8; i++) begin
        if (r[i] && ((i - m_ptr + 8) % 8) < bd) begin
          bd   = (i - m_ptr + 8) % 8;
          best = i;
        end
      end
      m_owner = best;
      m_last  = best;
      m_hold  = 0;
    end
  endtask

  task automatic tick(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #1;
    model_reset();
    chk("reset_outputs", 32'(dut_vec()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] r;
    logic       d;

    // From reset (ptr 0): single owner, wrap 6->7->0, withdrawal, done in idle.
    tbl[0]  = '{8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[1]  = '{8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[2]  = '{8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[3]  = '{8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[5]  = '{8'h40, 1'b0, 1'b1, 3'd6, 8'h40, 1'b1};
    tbl[6]  = '{8'hC1, 1'b1, 1'b0, 3'd6, 8'h00, 1'b1};
    tbl[7]  = '{8'h81, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0};
    tbl[8]  = '{8'h81, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[9]  = '{8'h81, 1'b1, 1'b0, 3'd7, 8'h00, 1'b1};
    tbl[10] = '{8'h81, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0};
    tbl[11] = '{8'h81, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1};
    tbl[12] = '{8'h80, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[13] = '{8'h80, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[14] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 3'd7, 8'h00, 1'b1};
    tbl[16] = '{8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};
    tbl[17] = '{8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0};

    model_reset();

    // Idle with no requests.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(8'h00, 1'b0);
      chk("idle_quiet", 32'(dut_vec()), 32'h0);
    end

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].req, tbl[i].done);
      chk($sformatf("table[%0d]", i), 32'(dut_vec()),
          32'({tbl[i].v, tbl[i].idx, tbl[i].oh, tbl[i].b, 1'b0}));
    end

    // All requesting, done each grant: order 0..7,0 with two-cycle gaps.
    do_reset();
    tick(8'hFF, 1'b0);
    chk("ff_first_idx", 32'({gnt_valid, gnt_idx}), 32'({1'b1, 3'd0}));
    for (int k = 1; k <= 8; k++) begin
      tick(8'hFF, 1'b1);
      chk("ff_release", 32'({gnt_valid, busy}), 32'({1'b0, 1'b1}));
      tick(8'hFF, 1'b0);
      chk("ff_turnaround", 32'({gnt_valid, busy}), 32'h0);
      tick(8'hFF, 1'b0);
      chk("ff_order", 32'({gnt_valid, gnt_idx}), 32'({1'b1, 3'(k % 8)}));
      chk("ff_onehot_bits", 32'($countones(gnt_onehot)), 32'd1);
    end

    // Withdrawal of idx 3 moves pointer to 4; then reset mid-grant.
    do_reset();
    tick(8'h08, 1'b0);
    chk("wd_grant3", 32'(dut_vec()), 32'(model_vec()));
    tick(8'h00, 1'b0);
    chk("wd_release", 32'({gnt_valid, gnt_idx, gnt_onehot, busy}),
        32'({1'b0, 3'd3, 8'h00, 1'b1}));
    tick(8'h18, 1'b0);
    tick(8'h18, 1'b0);
    chk("wd_ptr4", 32'({gnt_valid, gnt_idx}), 32'({1'b1, 3'd4}));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midgrant", 32'(dut_vec()), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(8'h18, 1'b0);
    chk("reset_ptr0", 32'({gnt_valid, gnt_idx}), 32'({1'b1, 3'd3}));

`ifdef ARB_TIMEOUT_EN
    // Held request without done: forced release after MaxHold grant cycles.
    do_reset();
    tick(8'h04, 1'b0);
    n = 1;
    for (int i = 0; i < 20 && gnt_valid; i++) begin
      tick(8'h04, 1'b0);
      if (gnt_valid) n++;
    end
    chk("to_grant_len", 32'(n), 32'(MaxHold));
    chk("to_pulse", 32'({timeout, busy}), 32'({1'b1, 1'b1}));
    tick(8'h04, 1'b0);
    chk("to_pulse_end", 32'({timeout, busy}), 32'h0);
    tick(8'h04, 1'b0);
    chk("to_regrant", 32'({gnt_valid, gnt_idx}), 32'({1'b1, 3'd2}));
`else
    // Without the timeout option a grant is held indefinitely.
    do_reset();
    tick(8'h04, 1'b0);
    for (int i = 0; i < 20; i++) tick(8'h04, 1'b0);
    chk("hold_forever", 32'({gnt_valid, gnt_idx, timeout}), 32'({1'b1, 3'd2, 1'b0}));
`endif

    // Randomized traffic against the reference model.
    do_reset();
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      d = ($urandom_range(0, 5) == 0);
      tick(r, d);
      chk("random", 32'(dut_vec()), 32'(model_vec()));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
